// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - AXI4 read-channel responder backed by a 64-bit-word memory
//
// Serves AR bursts (FIXED / INCR / WRAP) from an internal word memory and
// returns R beats one per cycle while rready is high. A synchronous load
// port preloads or patches memory in any state.
//
// Optional feature macro: AXI_RD_LAT_EN
//   defined   : a WAIT state inserts RD_LATENCY cycles between the AR
//               handshake and the first R beat (RD_LATENCY=0 skips WAIT)
//   undefined : first R beat follows the AR handshake directly
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   s_axi_ar*           read address channel (id, addr, len, size, burst, valid/ready)
//   s_axi_r*            read data channel (id, data, resp, last, valid/ready)
//   ld_en/ld_addr/ld_data  memory load port (word indexed)

module axi_rd_responder #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 4096,
    parameter int RD_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [63:0]                  ld_data
);

    localparam int MW = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

`ifdef AXI_RD_LAT_EN
    localparam int WCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, WAIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1} state_t;
`endif

    state_t                  state;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic [7:0]              beat_cnt;
`ifdef AXI_RD_LAT_EN
    logic [WCW-1:0]          wait_cnt;
`endif

    logic [63:0]             mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    rd_oob;
    logic [63:0]             rd_word;
    logic                    ar_bad;
    logic                    beat_err;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [1:0]              beat_resp;

    // Address of the beat following 'a' for the given burst shape.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] c;
        logic [ADDR_WIDTH-1:0] base;
        b    = ADDR_WIDTH'(1) << size;
        // Wrap container is a power of two because only legal wrap lengths
        // produce good data; illegal ones are flagged and zeroed anyway.
        c    = ADDR_WIDTH'(9'({1'b0, len}) + 9'd1) << size;
        base = a & ~(c - ADDR_WIDTH'(1));
        case (burst)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = base | ((a + b) & (c - ADDR_WIDTH'(1)));
            default:     next_addr = a + b;
        endcase
    endfunction

    // Burst shapes that are answered with SLVERR on every beat.
    function automatic logic burst_illegal(
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_illegal = (size > 3'd3) || (burst == 2'd3) ||
                        ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign nxt_addr = next_addr(addr_q, len_q, size_q, burst_q);
    assign ar_bad   = burst_illegal(s_axi_arsize, s_axi_arlen, s_axi_arburst);

    // The word to be presented next is read at the edge that loads rdata:
    // from araddr on the AR handshake, from the advanced address on a beat
    // handshake, or from the captured address when leaving WAIT.
    always_comb begin
        rd_addr = addr_q;
        case (state)
            IDLE:    rd_addr = s_axi_araddr;
            BEAT:    rd_addr = nxt_addr;
            default: rd_addr = addr_q;
        endcase
        word_addr = rd_addr >> 3;
        rd_oob    = word_addr >= ADDR_WIDTH'(MEM_WORDS);
        rd_word   = mem[word_addr[MW-1:0]];
        beat_err  = ((state == IDLE) ? ar_bad : err_q) || rd_oob;
        beat_data = beat_err ? '0 : DATA_WIDTH'(rd_word);
        beat_resp = beat_err ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            beat_cnt      <= '0;
`ifdef AXI_RD_LAT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        id_q          <= s_axi_arid;
                        addr_q        <= s_axi_araddr;
                        len_q         <= s_axi_arlen;
                        size_q        <= s_axi_arsize;
                        burst_q       <= s_axi_arburst;
                        err_q         <= ar_bad;
                        beat_cnt      <= '0;
`ifdef AXI_RD_LAT_EN
                        if (RD_LATENCY > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WCW'(RD_LATENCY - 1);
                        end else begin
                            state        <= BEAT;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rid    <= s_axi_arid;
                            s_axi_rdata  <= beat_data;
                            s_axi_rresp  <= beat_resp;
                            s_axi_rlast  <= (s_axi_arlen == 8'd0);
                        end
`else
                        state        <= BEAT;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rid    <= s_axi_arid;
                        s_axi_rdata  <= beat_data;
                        s_axi_rresp  <= beat_resp;
                        s_axi_rlast  <= (s_axi_arlen == 8'd0);
`endif
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
`ifdef AXI_RD_LAT_EN
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state        <= BEAT;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rid    <= id_q;
                        s_axi_rdata  <= beat_data;
                        s_axi_rresp  <= beat_resp;
                        s_axi_rlast  <= (len_q == 8'd0);
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
`endif
                BEAT: begin
                    if (s_axi_rready) begin
                        if (beat_cnt == len_q) begin
                            state         <= IDLE;
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                        end else begin
                            addr_q      <= nxt_addr;
                            beat_cnt    <= beat_cnt + 8'd1;
                            s_axi_rdata <= beat_data;
                            s_axi_rresp <= beat_resp;
                            s_axi_rlast <= ((beat_cnt + 8'd1) == len_q);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - directed self-checking bench for axi_rd_responder
`timescale 1ns/1ps
module tb_axi_rd_responder;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int MWD = 4096;
`ifdef AXI_RD_LAT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [IDW-1:0]  s_axi_arid = '0;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic [7:0]      s_axi_arlen = '0;
    logic [2:0]      s_axi_arsize = '0;
    logic [1:0]      s_axi_arburst = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [IDW-1:0]  s_axi_rid;
    logic [63:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;
    logic            ld_en = 1'b0;
    logic [11:0]     ld_addr = '0;
    logic [63:0]     ld_data = '0;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    axi_rd_responder #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(64), .MEM_WORDS(MWD), .RD_LATENCY(4)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_addr = 12'(a);
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    // Issues one AR and returns in the cycle of the first R beat.
    task automatic send_ar(input int id, input logic [63:0] addr, input int len,
                           input int size, input int burst);
        int w;
        s_axi_arid    = IDW'(id);
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = 3'(size);
        s_axi_arburst = 2'(burst);
        s_axi_arvalid = 1'b1;
        w = 0;
        while (!s_axi_arready && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_accept arready=%b required=1", s_axi_arready);
        end
        step();
        s_axi_arvalid = 1'b0;
        w = 0;
        while (!s_axi_rvalid && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (w != LAT) begin
            errors++;
            $display("FAIL first_beat_latency cycles=%0d required=%0d", w, LAT);
        end
    endtask

    // Drains n beats, checking each against exp_data/exp_resp; toggle uses
    // rready pattern 1,0,0,1,0,0,... and checks outputs hold during stalls.
    task automatic collect(input string name, input int n, input int id, input bit toggle);
        int k;
        int c;
        bit held;
        logic [63:0] hd;
        logic hl;
        k = 0;
        c = 0;
        hd = '0;
        hl = 1'b0;
        while (k < n && c < 300) begin
            s_axi_rready = toggle ? (c % 3 == 0) : 1'b1;
            held = 1'b0;
            if (s_axi_rvalid) begin
                if (s_axi_rready) begin
                    checks++;
                    if (s_axi_rdata !== exp_data[k]) begin
                        errors++;
                        $display("FAIL %s_rdata beat=%0d got=%h required=%h", name, k, s_axi_rdata, exp_data[k]);
                    end
                    checks++;
                    if (s_axi_rresp !== exp_resp[k]) begin
                        errors++;
                        $display("FAIL %s_rresp beat=%0d got=%0d required=%0d", name, k, s_axi_rresp, exp_resp[k]);
                    end
                    checks++;
                    if (s_axi_rlast !== 1'(k == n - 1)) begin
                        errors++;
                        $display("FAIL %s_rlast beat=%0d got=%b required=%b", name, k, s_axi_rlast, (k == n - 1));
                    end
                    checks++;
                    if (s_axi_rid !== IDW'(id)) begin
                        errors++;
                        $display("FAIL %s_rid beat=%0d got=%0d required=%0d", name, k, s_axi_rid, id);
                    end
                    k++;
                end else begin
                    held = 1'b1;
                    hd   = s_axi_rdata;
                    hl   = s_axi_rlast;
                end
            end
            step();
            c++;
            if (held) begin
                checks++;
                if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== hd || s_axi_rlast !== hl) begin
                    errors++;
                    $display("FAIL %s_stall_hold rvalid=%b rdata=%h rlast=%b required=1 %h %b",
                             name, s_axi_rvalid, s_axi_rdata, s_axi_rlast, hd, hl);
                end
            end
        end
        s_axi_rready = 1'b0;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL %s_beat_count got=%0d required=%0d", name, k, n);
        end
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end rvalid=%b arready=%b required=0 1", name, s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl arready=%b rvalid=%b rlast=%b required=0 0 0",
                     s_axi_arready, s_axi_rvalid, s_axi_rlast);
        end
        checks++;
        if (s_axi_rid !== '0 || s_axi_rdata !== '0 || s_axi_rresp !== 2'd0) begin
            errors++;
            $display("FAIL reset_data rid=%0d rdata=%h rresp=%0d required=0 0 0",
                     s_axi_rid, s_axi_rdata, s_axi_rresp);
        end
        step();
        step();
        checks++;
        if (s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_arready_held got=%b required=0", s_axi_arready);
        end
        reset = 1'b1;
        step();
        checks++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release arready=%b rvalid=%b required=1 0", s_axi_arready, s_axi_rvalid);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) load(16'h40 + i, 64'h1000 + 64'(i));
        for (int i = 0; i < 8; i++) begin
            exp_data[i] = 64'h1000 + 64'((i + 2) % 8);
            exp_resp[i] = 2'd0;
        end
        send_ar(5, 64'h210, 7, 3, 2);
        collect("wrap", 8, 5, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) load(i, 64'hA0 + 64'(i));
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'hA0 + 64'(i);
            exp_resp[i] = 2'd0;
        end
        send_ar(1, 64'h0, 3, 3, 1);
        collect("stall", 4, 1, 1'b1);
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 3; i++) begin
            exp_data[i] = 64'hA1;
            exp_resp[i] = 2'd0;
        end
        send_ar(9, 64'h8, 2, 3, 0);
        collect("fixed", 3, 9, 1'b0);
    endtask

    task automatic test_oob();
        load(MWD - 2, 64'hBEEF0);
        load(MWD - 1, 64'hBEEF1);
        exp_data[0] = 64'hBEEF0; exp_resp[0] = 2'd0;
        exp_data[1] = 64'hBEEF1; exp_resp[1] = 2'd0;
        exp_data[2] = 64'h0;     exp_resp[2] = 2'd2;
        exp_data[3] = 64'h0;     exp_resp[3] = 2'd2;
        send_ar(2, 64'((MWD - 2) * 8), 3, 3, 1);
        collect("oob", 4, 2, 1'b0);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'h0;
            exp_resp[i] = 2'd2;
        end
        send_ar(7, 64'h0, 1, 4, 1);
        collect("err_size", 2, 7, 1'b0);
        send_ar(8, 64'h0, 2, 3, 2);
        collect("err_wraplen", 3, 8, 1'b0);
        send_ar(10, 64'h0, 0, 3, 3);
        collect("err_burst3", 1, 10, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        send_ar(3, 64'h0, 7, 3, 1);
        s_axi_rready = 1'b1;
        step();
        step();
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 64'hA2) begin
            errors++;
            $display("FAIL midrst_beat3 rvalid=%b rdata=%h required=1 a2", s_axi_rvalid, s_axi_rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop rvalid=%b arready=%b required=0 0", s_axi_rvalid, s_axi_arready);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 64'hA0 + 64'(i);
            exp_resp[i] = 2'd0;
        end
        send_ar(4, 64'h0, 3, 3, 1);
        collect("after_rst", 4, 4, 1'b0);
    endtask

    task automatic test_latency_load();
        send_ar(6, 64'h0, 3, 3, 1);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 64'hA0) begin
            errors++;
            $display("FAIL lat_beat0 rvalid=%b rdata=%h required=1 a0", s_axi_rvalid, s_axi_rdata);
        end
        load(1, 64'h5555);
        checks++;
        if (s_axi_rdata !== 64'hA0) begin
            errors++;
            $display("FAIL lat_stall_hold rdata=%h required=a0", s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rdata !== 64'h5555) begin
            errors++;
            $display("FAIL lat_loaded_next rdata=%h required=5555", s_axi_rdata);
        end
        load(1, 64'h6666);
        checks++;
        if (s_axi_rdata !== 64'h5555 || s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL lat_held_word rdata=%h rvalid=%b required=5555 1", s_axi_rdata, s_axi_rvalid);
        end
        s_axi_rready = 1'b1;
        step();
        checks++;
        if (s_axi_rdata !== 64'hA2 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL lat_beat2 rdata=%h rlast=%b required=a2 0", s_axi_rdata, s_axi_rlast);
        end
        step();
        checks++;
        if (s_axi_rdata !== 64'hA3 || s_axi_rlast !== 1'b1) begin
            errors++;
            $display("FAIL lat_beat3 rdata=%h rlast=%b required=a3 1", s_axi_rdata, s_axi_rlast);
        end
        step();
        s_axi_rready = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL lat_end rvalid=%b arready=%b required=0 1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stall();
        test_fixed();
        test_oob();
        test_errors();
        test_reset_mid_burst();
        test_latency_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel responder (subordinate) backed by an internal 64-bit-word memory.
- Serves AR bursts from a fetch-side initiator (e.g. the instruction cache) and returns R beats.
- Used as the memory model behind cache fill paths in block-level and subsystem benches.
- Includes a synchronous load port for preloading images.

Parameters:
- ID_WIDTH, 13, width of arid/rid.
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, R data width; only 64 is supported.
- MEM_WORDS, 4096, backing store depth in 64-bit words; power of two.
- RD_LATENCY, 4, extra cycles before the first beat; used only with AXI_RD_LAT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- s_axi_arid  in  ID_WIDTH  transaction id.
- s_axi_araddr  in  ADDR_WIDTH  start byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arsize  in  3  log2 bytes per beat.
- s_axi_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP.
- s_axi_arvalid  in  1  address valid.
- s_axi_arready  out  1  address accepted.
- s_axi_rid  out  ID_WIDTH  echoed arid.
- s_axi_rdata  out  DATA_WIDTH  beat data.
- s_axi_rresp  out  2  0=OKAY, 2=SLVERR.
- s_axi_rlast  out  1  final beat.
- s_axi_rvalid  out  1  beat valid.
- s_axi_rready  in  1  beat accepted.
- ld_en  in  1  load-port write strobe.
- ld_addr  in  $clog2(MEM_WORDS)  word index.
- ld_data  in  64  load data.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; arready=0 while reset=0; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0.
  - Memory contents are not cleared.
- States:
  - IDLE: arready=1. On arvalid&&arready, capture id, addr, len, size, burst; beat counter=0; go to BEAT.
  - WAIT: present only with AXI_RD_LAT_EN; see Optional Feature.
  - BEAT: rvalid=1.
    - On rvalid&&rready with counter==len: go to IDLE.
    - Otherwise: advance the address, increment the counter, stay in BEAT.
- Latency:
  - AR handshake in cycle T gives first rvalid in T+1.
  - One beat per cycle while rready is held high.
  - After the last beat's handshake, arready=1 in the next cycle; no AR overlap with R.
- R outputs:
  - rid, rdata, rresp and rlast are registered and held stable while rvalid&&!rready.
  - rlast=1 only when counter==len.
- Address generation, with beat bytes B = 1<<size:
  - FIXED: address constant for all beats.
  - INCR: addr += B per beat; 4KB crossing is not checked.
  - WRAP: container C = (len+1)*B, aligned down to C; addr = base + ((addr+B-base) mod C).
- Word index = addr[3+log2(MEM_WORDS)-1:3].
  - rdata is always the full 64-bit word; lane selection is the initiator's job.
- Errors (beat still issued, rdata=0, rresp=SLVERR):
  - size>3: whole burst.
  - WRAP with len not in {1,3,7,15}: whole burst.
  - burst=3: whole burst.
  - addr>>3 >= MEM_WORDS: that beat only.
- Load port:
  - ld_en writes mem[ld_addr] at the clock edge; usable in any state.
  - A write to the word currently held on rdata does not change rdata.
  - A later beat reads the updated word.
- Reset asserted mid-burst:
  - rvalid drops immediately; the burst is abandoned.
  - After reset deasserts, the block is in IDLE.

Optional Feature:
- Macro AXI_RD_LAT_EN.
- Defined:
  - After AR handshake go to WAIT.
  - Count RD_LATENCY cycles, then enter BEAT; first rvalid at T+1+RD_LATENCY.
  - RD_LATENCY=0 behaves as undefined.
  - Inter-beat timing is unchanged.
- Undefined: the WAIT state and its counter are absent; first rvalid at T+1.

Test Plan:
- Preload mem[0x40..0x47]=0x1000+i; AR addr=0x210, len=7, size=3, burst=WRAP, id=5, rready=1 -> 8 beats, rid=5, all OKAY.
  - rdata sequence: 0x1002..0x1007, then 0x1000, 0x1001.
  - rlast on beat 8 only; arready=1 one cycle after.
- AR addr=0x0, len=3, INCR, size=3; rready toggles 1,0,0,1,... -> rdata and rlast held stable during stalls; exactly 4 handshakes.
- AR addr=(MEM_WORDS-2)*8, len=3, INCR -> beats 1-2 OKAY with stored data; beats 3-4 SLVERR with rdata=0.
- AR size=4 or WRAP with len=2 -> len+1 beats, all SLVERR, rlast on the final beat.
- Assert reset=0 after 2 beats of a len=7 burst -> rvalid=0 immediately.
  - After release, a new AR at 0x0 completes normally; preloaded data is intact.
- With AXI_RD_LAT_EN and RD_LATENCY=4: AR handshake at T -> first rvalid at T+5.
  - Load-port write to the next word during a stall -> that beat returns the new value.
